// File: rtl/core_ctrl.sv
// Job sequencer for the memory controller and processing unit: walks each
// operand pair through store/transfer/process, then drains the pipe.
module core_ctrl #(
    parameter logic [7:0] WDOG_MAX = 8'd255
) (
    input  logic       mc_clk,
    input  logic       mc_reset,
    input  logic       cc_start,
    input  logic       cc_abort,
    input  logic [5:0] cc_length,
    input  logic       mc_done,
    input  logic       mc_data_done,
    input  logic       pu_done,
    output logic [2:0] mc_data_contition,
    output logic [5:0] mc_data_length,
    output logic       pu_load,
    output logic       pu_start,
    output logic       cc_busy,
    output logic       cc_done,
    output logic       cc_error,
    output logic [5:0] cc_pair_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STORE  = 3'd1,
        S_XFER   = 3'd2,
        S_PROC   = 3'd3,
        S_DRAIN1 = 3'd4,
        S_DRAIN2 = 3'd5,
        S_DRAIN3 = 3'd6
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] wdog_reg, wdog_next;
    logic [5:0] length_next;
    logic [5:0] pair_count_next;
    logic       error_next;
    logic [2:0] cmd_next;
    logic       pu_load_next, pu_start_next, busy_next, done_next;
    logic       in_wait, wdog_hit;

    function automatic logic [2:0] cmd_of(input state_t s);
        case (s)
            S_STORE:  cmd_of = 3'b100;
            S_XFER:   cmd_of = 3'b010;
            S_PROC:   cmd_of = 3'b001;
            S_DRAIN1: cmd_of = 3'b010;
            S_DRAIN2: cmd_of = 3'b001;
            default:  cmd_of = 3'b000;
        endcase
    endfunction

    // The watchdog counter restarts on every state change, so it doubles as
    // the "cycles spent in this state" index used to mask stale flags.
    always_comb begin
        state_next      = state_reg;
        length_next     = mc_data_length;
        pair_count_next = cc_pair_count;
        error_next      = cc_error;
        in_wait         = (state_reg == S_STORE) || (state_reg == S_XFER) ||
                          (state_reg == S_PROC);
        wdog_hit        = in_wait &&
                          (({1'b0, wdog_reg} + 9'd1) >= {1'b0, WDOG_MAX});

        case (state_reg)
            S_IDLE: begin
                if (cc_start) begin
                    length_next     = cc_length;
                    pair_count_next = 6'd0;
                    error_next      = 1'b0;
                    state_next      = S_STORE;
                end
            end
            S_STORE, S_XFER, S_PROC: begin
                if (cc_abort || wdog_hit) begin
                    error_next = 1'b1;
                    state_next = S_DRAIN1;
                end else begin
                    case (state_reg)
                        S_STORE: begin
                            if (mc_done) state_next = S_XFER;
                        end
                        S_XFER: begin
                            if (mc_done && (wdog_reg != 8'd0))
                                state_next = mc_data_done ? S_DRAIN1 : S_PROC;
                        end
                        default: begin
                            // pu_done only counts once the pu_start cycle is over
                            if (pu_done && (wdog_reg >= 8'd2)) begin
                                if (cc_pair_count != 6'd63)
                                    pair_count_next = cc_pair_count + 6'd1;
                                state_next = S_XFER;
                            end
                        end
                    endcase
                end
            end
            S_DRAIN1: state_next = S_DRAIN2;
            S_DRAIN2: state_next = S_DRAIN3;
            default:  state_next = S_IDLE;
        endcase

        if (state_next != state_reg)
            wdog_next = 8'd0;
        else if (in_wait)
            wdog_next = wdog_reg + 8'd1;
        else
            wdog_next = 8'd0;

        cmd_next      = cmd_of(state_next);
        pu_load_next  = (state_next == S_PROC) && (state_reg != S_PROC);
        pu_start_next = (state_next == S_PROC) && (state_reg == S_PROC) &&
                        (wdog_reg == 8'd0);
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_next == S_DRAIN3);
    end

    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state_reg         <= S_IDLE;
            wdog_reg          <= 8'd0;
            mc_data_contition <= 3'b000;
            mc_data_length    <= 6'd0;
            pu_load           <= 1'b0;
            pu_start          <= 1'b0;
            cc_busy           <= 1'b0;
            cc_done           <= 1'b0;
            cc_error          <= 1'b0;
            cc_pair_count     <= 6'd0;
        end else begin
            state_reg         <= state_next;
            wdog_reg          <= wdog_next;
            mc_data_contition <= cmd_next;
            mc_data_length    <= length_next;
            pu_load           <= pu_load_next;
            pu_start          <= pu_start_next;
            cc_busy           <= busy_next;
            cc_done           <= done_next;
            cc_error          <= error_next;
            cc_pair_count     <= pair_count_next;
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: table of whole jobs run against memory/PU models,
// plus hand-driven sequences for reset, watchdog and stale-flag corners.
module tb_core_ctrl;

    localparam logic [7:0] WDOG = 8'd20;

    logic       mc_clk;
    logic       mc_reset;
    logic       cc_start;
    logic [5:0] cc_length;
    logic       cc_abort, mc_done, mc_data_done, pu_done;
    logic [2:0] mc_data_contition;
    logic [5:0] mc_data_length;
    logic       pu_load, pu_start, cc_busy, cc_done, cc_error;
    logic [5:0] cc_pair_count;

    // hand-driven and model-driven copies of the DUT inputs
    logic model_en = 1'b0;
    logic h_abort = 1'b0, h_mc_done = 1'b0, h_data_done = 1'b0, h_pu_done = 1'b0;
    logic m_abort = 1'b0, m_mc_done = 1'b0, m_data_done = 1'b0, m_pu_done = 1'b0;
    int   m_limit = 0, m_abort_pair = 0;
    int   m_age = 0, m_xfers = 0, m_pairs = 0, m_pcnt = 0;
    logic [2:0] m_prev = 3'b000;

    assign cc_abort     = h_abort     | (model_en & m_abort);
    assign mc_done      = h_mc_done   | (model_en & m_mc_done);
    assign mc_data_done = h_data_done | (model_en & m_data_done);
    assign pu_done      = h_pu_done   | (model_en & m_pu_done);

    int n_checks = 0, n_pass = 0;
    int n_load = 0, n_start = 0, n_done = 0;
    logic [2:0] mon_last = 3'b000;
    logic [2:0] seq_log[$];

    core_ctrl #(.WDOG_MAX(WDOG)) dut (
        .mc_clk(mc_clk), .mc_reset(mc_reset), .cc_start(cc_start),
        .cc_abort(cc_abort), .cc_length(cc_length), .mc_done(mc_done),
        .mc_data_done(mc_data_done), .pu_done(pu_done),
        .mc_data_contition(mc_data_contition), .mc_data_length(mc_data_length),
        .pu_load(pu_load), .pu_start(pu_start), .cc_busy(cc_busy),
        .cc_done(cc_done), .cc_error(cc_error), .cc_pair_count(cc_pair_count)
    );

    initial mc_clk = 1'b0;
    always #5 mc_clk = ~mc_clk;

    // Memory model: mc_done 4 cycles into STORE, 2 cycles into XFER.
    // PU model: pu_done 3 cycles after pu_start, optional abort on pair N.
    always @(negedge mc_clk) begin
        if (mc_data_contition != m_prev) m_age = 0;
        else m_age++;
        m_prev = mc_data_contition;
        if (mc_data_contition == 3'b100 && m_age == 0) begin
            m_xfers = 0; m_pairs = 0; m_pcnt = 0;
        end
        m_mc_done = 1'b0; m_data_done = 1'b0; m_pu_done = 1'b0; m_abort = 1'b0;
        if (mc_data_contition == 3'b100 && m_age == 3) m_mc_done = 1'b1;
        if (mc_data_contition == 3'b010 && m_age == 1) begin
            m_mc_done   = 1'b1;
            m_data_done = (m_xfers == m_limit);
            m_xfers++;
        end
        if (pu_start) m_pcnt = 1;
        else if (m_pcnt != 0) m_pcnt++;
        if (m_pcnt == 4) begin
            m_pcnt = 0;
            m_pu_done = 1'b1;
            m_pairs++;
            if (m_pairs == m_abort_pair) m_abort = 1'b1;
        end
    end

    always @(negedge mc_clk) begin
        if (pu_load)  n_load++;
        if (pu_start) n_start++;
        if (cc_done)  n_done++;
        if (mc_data_contition != mon_last) seq_log.push_back(mc_data_contition);
        mon_last = mc_data_contition;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && n_done == d0; i++) @(negedge mc_clk);
    endtask

    typedef struct {
        logic [5:0] len;
        int mlen;
        int apair;
        int exp_pairs;
        int exp_err;
        int exp_loads;
    } vec_t;

    vec_t vecs[7];

    task automatic run_job(input int idx, input vec_t v);
        int base, d0, l0, s0, diffs;
        logic [2:0] exp_q[$];
        base = seq_log.size(); d0 = n_done; l0 = n_load; s0 = n_start;
        m_limit = v.mlen; m_abort_pair = v.apair;
        cc_length = v.len; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        wait_done(d0, 3000);
        repeat (3) @(negedge mc_clk);
        check("job_done_count", n_done - d0, 1);
        check("job_pairs", cc_pair_count, v.exp_pairs);
        check("job_error", cc_error, v.exp_err);
        check("job_loads", n_load - l0, v.exp_loads);
        check("job_starts", n_start - s0, v.exp_loads);
        check("job_length", mc_data_length, v.len);
        check("job_idle", cc_busy, 0);
        exp_q.push_back(3'b100);
        for (int i = 0; i < v.exp_loads; i++) begin
            exp_q.push_back(3'b010); exp_q.push_back(3'b001);
        end
        exp_q.push_back(3'b010); exp_q.push_back(3'b001); exp_q.push_back(3'b000);
        diffs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= seq_log.size() || seq_log[base + i] !== exp_q[i]) diffs++;
        check("job_seq_len", seq_log.size() - base, exp_q.size());
        check("job_seq_diffs", diffs, 0);
        $display("job %0d len=%0d pairs=%0d err=%0d loads=%0d", idx, v.len,
                 cc_pair_count, cc_error, n_load - l0);
    endtask

    initial begin
        int d0, cnt;
        vecs[0] = '{6'd3,  3,  0, 3,  0, 3};
        vecs[1] = '{6'd0,  0,  0, 0,  0, 0};
        vecs[2] = '{6'd3,  3,  2, 1,  1, 2};
        vecs[3] = '{6'd1,  1,  0, 1,  0, 1};
        vecs[4] = '{6'd5,  5,  1, 0,  1, 1};
        vecs[5] = '{6'd63, 65, 0, 63, 0, 65};
        vecs[6] = '{6'd2,  2,  0, 2,  0, 2};

        mc_reset = 1'b1; cc_start = 1'b0; cc_length = 6'd0;
        repeat (3) @(negedge mc_clk);
        check("rst_cmd", mc_data_contition, 0);
        check("rst_busy", cc_busy, 0);
        check("rst_err", cc_error, 0);
        check("rst_pairs", cc_pair_count, 0);
        mc_reset = 1'b0;
        @(negedge mc_clk);
        $display("reset released");

        model_en = 1'b1;
        for (int i = 0; i < 7; i++) run_job(i, vecs[i]);

        // Asynchronous reset during PROC, then start in the first cycle after
        m_limit = 2; m_abort_pair = 0;
        cc_length = 6'd2; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        for (int i = 0; i < 50 && !pu_load; i++) @(negedge mc_clk);
        check("proc_reached", pu_load, 1);
        d0 = n_done;
        #2 mc_reset = 1'b1;
        #1;
        check("arst_cmd", mc_data_contition, 0);
        check("arst_len", mc_data_length, 0);
        check("arst_load", pu_load, 0);
        check("arst_start", pu_start, 0);
        check("arst_busy", cc_busy, 0);
        check("arst_done", cc_done, 0);
        check("arst_err", cc_error, 0);
        check("arst_pairs", cc_pair_count, 0);
        @(negedge mc_clk);
        m_limit = 1;
        mc_reset = 1'b0; cc_length = 6'd1; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        check("post_rst_busy", cc_busy, 1);
        check("post_rst_cmd", mc_data_contition, 3'b100);
        check("abandoned_no_done", n_done - d0, 0);
        wait_done(d0, 500);
        repeat (3) @(negedge mc_clk);
        check("post_rst_done", n_done - d0, 1);
        check("post_rst_pairs", cc_pair_count, 1);
        $display("reset during PROC sequence done");

        // Watchdog timeout in STORE, then a fresh start clears the error
        model_en = 1'b0;
        cc_length = 6'd4; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        d0 = n_done; cnt = 0;
        for (int i = 0; i < 100 && mc_data_contition == 3'b100; i++) begin
            cnt++;
            @(negedge mc_clk);
        end
        check("wdog_cycles", cnt, WDOG);
        check("wdog_err", cc_error, 1);
        check("wdog_drain1", mc_data_contition, 3'b010);
        wait_done(d0, 20);
        check("wdog_done", n_done - d0, 1);
        repeat (3) @(negedge mc_clk);
        cc_length = 6'd2; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0;
        check("restart_clears_err", cc_error, 0);
        h_abort = 1'b1;
        @(negedge mc_clk);
        h_abort = 1'b0;
        check("abort_err", cc_error, 1);
        check("abort_drain1", mc_data_contition, 3'b010);
        repeat (4) @(negedge mc_clk);
        h_abort = 1'b1;
        @(negedge mc_clk);
        h_abort = 1'b0;
        check("idle_abort_busy", cc_busy, 0);
        check("idle_abort_cmd", mc_data_contition, 0);
        check("idle_len_held", mc_data_length, 2);
        $display("watchdog and abort sequence done");

        // Stale mc_done in first XFER cycle, start while busy, early pu_done
        cc_length = 6'd1; cc_start = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b0; h_mc_done = 1'b1;
        @(negedge mc_clk);
        cc_start = 1'b1; cc_length = 6'd9;
        @(negedge mc_clk);
        h_mc_done = 1'b0; cc_start = 1'b0;
        check("stale_still_xfer", mc_data_contition, 3'b010);
        check("stale_no_load", pu_load, 0);
        check("busy_start_len", mc_data_length, 1);
        h_mc_done = 1'b1;
        @(negedge mc_clk);
        h_mc_done = 1'b0;
        check("proc1_cmd", mc_data_contition, 3'b001);
        check("proc1_load", pu_load, 1);
        h_pu_done = 1'b1;
        @(negedge mc_clk);
        check("proc2_start", pu_start, 1);
        check("proc2_load", pu_load, 0);
        @(negedge mc_clk);
        check("early_pu_done_ignored", mc_data_contition, 3'b001);
        check("early_pairs", cc_pair_count, 0);
        @(negedge mc_clk);
        h_pu_done = 1'b0;
        check("pair_back_xfer", mc_data_contition, 3'b010);
        check("pair_count_one", cc_pair_count, 1);
        @(negedge mc_clk);
        h_mc_done = 1'b1; h_data_done = 1'b1;
        @(negedge mc_clk);
        h_mc_done = 1'b0; h_data_done = 1'b0;
        @(negedge mc_clk);
        @(negedge mc_clk);
        check("drain3_done", cc_done, 1);
        check("drain3_cmd", mc_data_contition, 0);
        @(negedge mc_clk);
        check("done_one_cycle", cc_done, 0);
        check("final_err", cc_error, 0);
        check("final_len", mc_data_length, 1);
        $display("stale flag sequence done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
